// File: rtl/dice_pe_cfg_ctrl.sv
// Per-PE configuration and dynamic-control stage.
// Loads 2-word config packets into a shadow, commits to active, sequences DFF modes.
module dice_pe_cfg_ctrl #(
    parameter logic [7:0] PE_ID  = 8'd0,
    parameter logic [3:0] MAGIC  = 4'hA,
    parameter int         ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [31:0]       cfg_data,
    input  logic              cfg_commit,
    input  logic              iter_start,
    output logic [31:0]       opcode,
    output logic              out_sel,
    output logic              dff_input_mode,
    output logic              dff_output_mode,
    output logic              cfg_pending,
    output logic              cfg_err,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_OPC  = 2'd1,
        S_SKIP = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Header flag bits: [2] out_follow, [1] dff_en, [0] out_sel
    logic [2:0]        hdr_tmp_q, hdr_tmp_d;
    logic [2:0]        sh_bits_q, sh_bits_d;
    logic [31:0]       sh_opc_q, sh_opc_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic [2:0]        act_bits_q;
    logic [31:0]       act_opc_q;
    logic              din_q, dout_q;
    logic [ITER_W-1:0] iter_q;

    logic accept;
    logic commit_fire;
    logic hdr_magic_ok;
    logic hdr_id_ok;

    assign cfg_ready    = (state_q != S_OPC) || !pend_q;
    assign accept       = cfg_valid && cfg_ready;
    assign commit_fire  = cfg_commit && pend_q;
    assign hdr_magic_ok = (cfg_data[31:28] == MAGIC);
    assign hdr_id_ok    = (cfg_data[27:20] == PE_ID);

    // Packet FSM next-state, shadow staging and sticky error
    always_comb begin
        state_d   = state_q;
        hdr_tmp_d = hdr_tmp_q;
        sh_bits_d = sh_bits_q;
        sh_opc_d  = sh_opc_q;
        pend_d    = pend_q;
        err_d     = err_q;
        if (commit_fire) begin
            pend_d = 1'b0;
        end
        case (state_q)
            S_HDR: begin
                if (accept) begin
                    if (!hdr_magic_ok) begin
                        err_d = 1'b1;
                    end else if (hdr_id_ok) begin
                        hdr_tmp_d = cfg_data[2:0];
                        state_d   = S_OPC;
                    end else begin
                        state_d = S_SKIP;
                    end
                end
            end
            S_OPC: begin
                if (accept) begin
                    sh_opc_d  = cfg_data;
                    sh_bits_d = hdr_tmp_q;
                    pend_d    = 1'b1;
                    state_d   = S_HDR;
                end
            end
            S_SKIP: begin
                if (accept) begin
                    state_d = S_HDR;
                end
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    // Packet FSM and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HDR;
            hdr_tmp_q <= '0;
            sh_bits_q <= '0;
            sh_opc_q  <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_tmp_q <= hdr_tmp_d;
            sh_bits_q <= sh_bits_d;
            sh_opc_q  <= sh_opc_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
        end
    end

    // Active config, iteration counter and mode sequencing (old active config)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_bits_q <= '0;
            act_opc_q  <= '0;
            din_q      <= 1'b0;
            dout_q     <= 1'b0;
            iter_q     <= '0;
        end else begin
            if (commit_fire) begin
                act_bits_q <= sh_bits_q;
                act_opc_q  <= sh_opc_q;
                iter_q     <= '0;
            end else if (iter_start) begin
                iter_q <= iter_q + {{(ITER_W-1){1'b0}}, 1'b1};
            end
            if (iter_start && act_bits_q[1]) begin
                din_q <= ~din_q;
                if (act_bits_q[2]) begin
                    dout_q <= din_q;
                end
            end
        end
    end

    assign opcode          = act_opc_q;
    assign out_sel         = act_bits_q[0];
    assign dff_input_mode  = din_q;
    assign dff_output_mode = dout_q;
    assign cfg_pending     = pend_q;
    assign cfg_err         = err_q;
    assign iter_cnt        = iter_q;

endmodule

// File: tb/tb_dice_pe_cfg_ctrl.sv
// Testbench for dice_pe_cfg_ctrl.
// Directed packets plus random traffic against a packet-level reference model.
module tb_dice_pe_cfg_ctrl;

    localparam int ITER_W = 16;

    logic              clk;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [31:0]       cfg_data;
    logic              cfg_commit;
    logic              iter_start;
    logic [31:0]       opcode;
    logic              out_sel;
    logic              dff_input_mode;
    logic              dff_output_mode;
    logic              cfg_pending;
    logic              cfg_err;
    logic [ITER_W-1:0] iter_cnt;

    dice_pe_cfg_ctrl #(
        .PE_ID (8'd0),
        .MAGIC (4'hA),
        .ITER_W(ITER_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_data       (cfg_data),
        .cfg_commit     (cfg_commit),
        .iter_start     (iter_start),
        .opcode         (opcode),
        .out_sel        (out_sel),
        .dff_input_mode (dff_input_mode),
        .dff_output_mode(dff_output_mode),
        .cfg_pending    (cfg_pending),
        .cfg_err        (cfg_err),
        .iter_cnt       (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // Reference model: where we are in the current packet, and what it holds
    bit              m_in_pkt;
    bit              m_mine;
    bit [2:0]        m_hdr;
    bit [31:0]       m_sh_opc;
    bit [2:0]        m_sh_bits;
    bit              m_pend;
    bit [31:0]       m_act_opc;
    bit              m_follow;
    bit              m_dffen;
    bit              m_osel;
    bit              m_in;
    bit              m_out;
    bit              m_err;
    int              m_iter;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    endtask

    function automatic bit m_ready();
        return !(m_in_pkt && m_mine && m_pend);
    endfunction

    task automatic m_reset();
        m_in_pkt  = 0; m_mine = 0; m_hdr = 0;
        m_sh_opc  = 0; m_sh_bits = 0; m_pend = 0;
        m_act_opc = 0; m_follow = 0; m_dffen = 0; m_osel = 0;
        m_in = 0; m_out = 0; m_err = 0; m_iter = 0;
    endtask

    task automatic m_step(input bit v, input bit [31:0] d,
                          input bit c, input bit s);
        bit acc;
        bit do_commit;
        bit old_in;
        acc       = v && m_ready();
        do_commit = c && m_pend;
        old_in    = m_in;
        if (s && m_dffen) begin
            m_in = !old_in;
            if (m_follow) m_out = old_in;
        end
        if (do_commit) begin
            m_act_opc = m_sh_opc;
            m_follow  = m_sh_bits[2];
            m_dffen   = m_sh_bits[1];
            m_osel    = m_sh_bits[0];
            m_pend    = 0;
            m_iter    = 0;
        end else if (s) begin
            m_iter = (m_iter + 1) % (1 << ITER_W);
        end
        if (acc) begin
            if (!m_in_pkt) begin
                if (d[31:28] != 4'hA) begin
                    m_err = 1;
                end else begin
                    m_in_pkt = 1;
                    m_mine   = (d[27:20] == 8'd0);
                    m_hdr    = d[2:0];
                end
            end else begin
                if (m_mine) begin
                    m_sh_opc  = d;
                    m_sh_bits = m_hdr;
                    m_pend    = 1;
                end
                m_in_pkt = 0;
            end
        end
    endtask

    task automatic chk_all(input string ph);
        chk({ph, "_rdy"},  32'(cfg_ready), 32'(m_ready()));
        chk({ph, "_opc"},  opcode, m_act_opc);
        chk({ph, "_osel"}, 32'(out_sel), 32'(m_osel));
        chk({ph, "_din"},  32'(dff_input_mode), 32'(m_in));
        chk({ph, "_dout"}, 32'(dff_output_mode), 32'(m_out));
        chk({ph, "_pend"}, 32'(cfg_pending), 32'(m_pend));
        chk({ph, "_err"},  32'(cfg_err), 32'(m_err));
        chk({ph, "_iter"}, 32'(iter_cnt), 32'(m_iter));
    endtask

    // One clock: drive, check pre-edge view, advance model, let edge happen
    task automatic cyc(input bit v, input bit [31:0] d,
                       input bit c, input bit s);
        cfg_valid  = v;
        cfg_data   = d;
        cfg_commit = c;
        iter_start = s;
        #1;
        chk_all("pre");
        m_step(v, d, c, s);
        @(posedge clk);
        #1;
        cfg_valid  = 0;
        cfg_commit = 0;
        iter_start = 0;
        cfg_data   = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        m_reset();
        chk_all("rst");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [31:0] d;
        bit        v;
        n_chk = 0;
        n_pass = 0;
        cfg_valid = 0;
        cfg_data = 0;
        cfg_commit = 0;
        iter_start = 0;
        rst_n = 1;
        #3;
        do_reset();
        chk("rst_ready", 32'(cfg_ready), 32'd1);

        // Basic load and commit
        cyc(1, 32'hA000_0003, 0, 0);
        cyc(1, 32'h0000_0015, 0, 0);
        chk("ld_pend", 32'(cfg_pending), 32'd1);
        cyc(0, 0, 1, 0);
        chk("ld_opc", opcode, 32'h15);
        chk("ld_osel", 32'(out_sel), 32'd1);
        chk("ld_pend0", 32'(cfg_pending), 32'd0);
        chk("ld_modes", 32'({dff_input_mode, dff_output_mode}), 32'd0);

        // Foreign packet is consumed and dropped
        cyc(1, 32'hA050_0000, 0, 0);
        cyc(1, 32'h0000_DEAD, 0, 0);
        chk("skip_pend", 32'(cfg_pending), 32'd0);
        chk("skip_opc", opcode, 32'h15);

        // Bad magic is sticky; a later good packet still loads
        cyc(1, 32'h3000_0000, 0, 0);
        chk("bad_err", 32'(cfg_err), 32'd1);
        chk("bad_rdy", 32'(cfg_ready), 32'd1);
        cyc(1, 32'hA000_0006, 0, 0);
        cyc(1, 32'h0000_0077, 0, 0);
        cyc(0, 0, 1, 0);
        chk("bad_opc", opcode, 32'h77);
        chk("bad_err2", 32'(cfg_err), 32'd1);

        // Mode sequencing with dff_en and out_follow
        cyc(0, 0, 0, 1);
        chk("it1", 32'({dff_input_mode, dff_output_mode}), 32'b10);
        cyc(0, 0, 0, 1);
        chk("it2", 32'({dff_input_mode, dff_output_mode}), 32'b01);
        cyc(0, 0, 0, 1);
        chk("it3", 32'({dff_input_mode, dff_output_mode}), 32'b10);
        chk("it_cnt", 32'(iter_cnt), 32'd3);

        // Back-pressure while a packet is pending
        cyc(1, 32'hA000_0001, 0, 0);
        cyc(1, 32'h0000_0011, 0, 0);
        cyc(1, 32'hA000_0002, 0, 0);
        chk("bp_rdy0", 32'(cfg_ready), 32'd0);
        cyc(1, 32'h0000_0022, 1, 0);
        chk("bp_rdy1", 32'(cfg_ready), 32'd1);
        chk("bp_opc", opcode, 32'h11);
        cyc(1, 32'h0000_0022, 0, 0);
        chk("bp_pend", 32'(cfg_pending), 32'd1);

        // Commit together with iter_start uses the old config
        cyc(0, 0, 1, 1);
        chk("ci_din", 32'(dff_input_mode), 32'd1);
        chk("ci_cnt", 32'(iter_cnt), 32'd0);
        cyc(0, 0, 0, 1);
        chk("ci_din2", 32'(dff_input_mode), 32'd0);
        chk("ci_dout2", 32'(dff_output_mode), 32'd0);
        chk("ci_cnt2", 32'(iter_cnt), 32'd1);

        // Reset mid-packet drops the partial packet
        cyc(1, 32'hA000_0004, 0, 0);
        do_reset();
        cyc(1, 32'h0000_0099, 0, 0);
        chk("mid_err", 32'(cfg_err), 32'd1);
        chk("mid_pend", 32'(cfg_pending), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (!m_in_pkt) begin
                d = $urandom;
                d[31:28] = ($urandom_range(0, 7) == 0) ? 4'h5 : 4'hA;
                d[27:20] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
            end else begin
                d = $urandom;
            end
            cyc(v, d, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0));
            if (i == 1500) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
